counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Command-driven controller for a binary up/down modulo-2^WIDTH counter with clock enable. It accepts a run command over a valid/ready handshake and steps the counter a programmed number of times, in a chosen direction, at a programmed rate. It reports each step, each wrap-around and completion. It sits between control logic (or a user FSM) and the counter datapath, so callers never drive the counter's enable directly.

## Interface
- WIDTH, 4, counter width in bits; legal range 2–8; counter wraps modulo 2^WIDTH.
- DIV_W, 8, width of the rate-divider field.

- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset; one clock, synchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_up  input  1  direction: 1 = up, 0 = down.
- cmd_clr  input  1  1 = load Q to 0 at acceptance, before counting.
- cmd_len  input  WIDTH  number of steps to perform (0 allowed).
- cmd_div  input  DIV_W  one step every cmd_div+1 cycles.
- abort  input  1  cancel the running command.
- Q  output  WIDTH  counter value, registered.
- step  output  1  one-cycle pulse, high in the cycle after Q changed.
- wrap  output  1  one-cycle pulse coincident with step when the step crossed max↔0.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse: command finished normally.

## Operation
- States: IDLE, RUN, DONE.
- cmd_ready = (state == IDLE) & ~rst, combinational.
- Acceptance (accept edge): cmd_valid & cmd_ready at a rising edge.
  - Latch dir, div_reg ← cmd_div, presc ← cmd_div, rem ← cmd_len.
  - If cmd_clr, Q ← 0.
  - Next state is RUN if cmd_len ≠ 0, else DONE.
- RUN, per cycle (abort has priority):
  - abort = 1: state ← IDLE. No step, no done, Q holds.
  - Else, presc ≠ 0: presc ← presc − 1.
  - Else, presc = 0: perform a step and reload presc ← div_reg.
- Step:
  - up: Q ← (Q == 2^WIDTH−1) ? 0 : Q+1.
  - down: Q ← (Q == 0) ? 2^WIDTH−1 : Q−1.
  - step ← 1; wrap ← 1 if the wrap branch was taken.
  - rem ← rem − 1. If rem was 1, state ← DONE.
- DONE: done = 1 for exactly one cycle; state ← IDLE on the next edge. Commands are not accepted in DONE.
- Q persists across commands unless cmd_clr is set. A new command continues from the current Q.
- abort in IDLE or DONE is ignored.
- cmd_* inputs are sampled only at acceptance. Changes during RUN have no effect.

## Timing
- Reset: on the edge with rst = 1, Q = 0, state = IDLE, step = 0, wrap = 0, busy = 0, done = 0, presc = 0, rem = 0.
  - cmd_ready is 0 while rst is high and 1 in the first cycle after.
  - rst mid-RUN or mid-DONE discards the command and produces no done.
- Accept edge at cycle k:
  - Step n (1..len) updates Q at edge k + n·(div+1).
  - step/wrap are high in the cycle following that edge.
  - busy is high from cycle k+1 through the cycle ending with the last step edge.
  - done is high in the cycle after the last step edge. cmd_ready returns one cycle later.
- cmd_len = 0: done is high in the cycle after the accept edge; no step, Q unchanged (or 0 if cmd_clr).
- Throughput: minimum gap between accepts is len·(div+1) + 2 cycles.
- step and wrap are never asserted outside RUN-generated steps. done and busy are never both high.

## Test plan
- Reset → Q = 0, busy = done = step = wrap = 0. cmd_ready = 0 during rst and 1 the cycle after rst drops.
- From Q = 0: up, len = 3, div = 0, accept at edge k → Q = 1, 2, 3 after edges k+1..k+3. step high 3 cycles, wrap never. done high one cycle after edge k+3. cmd_ready high again the cycle after that.
- down, clr = 1, len = 2, div = 0 → Q = 0 at accept, then 15 with wrap = 1, then 14 with wrap = 0. done pulse. Repeat up len = 2 from 14 → 15, then 0 with wrap = 1.
- up, len = 2, div = 2, from Q = 5 → Q = 6 at edge k+3 and Q = 7 at edge k+6. step pulses exactly 2. busy for 6 cycles.
- up, len = 10, div = 0; assert abort in the 3rd RUN cycle → Q = 2 (from 0), no third step, no done. cmd_ready = 1 the next cycle. A following command is accepted normally.
- Boundary cases:
  - len = 0 → done the cycle after accept, no step, Q unchanged.
  - rst asserted mid-run with len = 8 → Q = 0, IDLE, no done.
  - cmd_valid held during RUN/DONE → not accepted until IDLE.

Source files
------------

// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if: command handshake, abort and status bundle for the counter sequencer.
interface counter_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_up;
    logic             cmd_clr;
    logic [WIDTH-1:0] cmd_len;
    logic [DIV_W-1:0] cmd_div;
    logic             abort;
    logic [WIDTH-1:0] Q;
    logic             step;
    logic             wrap;
    logic             busy;
    logic             done;
    modport master (
        output cmd_valid, cmd_up, cmd_clr, cmd_len, cmd_div, abort,
        input  cmd_ready, Q, step, wrap, busy, done
    );
    modport slave (
        input  cmd_valid, cmd_up, cmd_clr, cmd_len, cmd_div, abort,
        output cmd_ready, Q, step, wrap, busy, done
    );
endinterface

// File: rtl/counter_sequencer.sv
// counter_sequencer: runs a modulo-2^WIDTH up/down counter for a commanded number of steps at a programmed rate.
module counter_sequencer #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8
) (
    input  logic clk,
    input  logic rst,
    counter_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [WIDTH-1:0] QMAX = '1;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d, rem_q, rem_d;
    logic [DIV_W-1:0] div_q, div_d, presc_q, presc_d;
    logic             dir_q, dir_d, step_q, step_d, wrap_q, wrap_d;
    logic             accept, at_edge;
    assign bus.cmd_ready = (state_q == IDLE) & ~rst;
    assign accept        = bus.cmd_valid & bus.cmd_ready;
    assign at_edge       = dir_q ? (q_q == QMAX) : (q_q == '0);
    assign bus.Q         = q_q;
    assign bus.step      = step_q;
    assign bus.wrap      = wrap_q;
    assign bus.busy      = state_q == RUN;
    assign bus.done      = state_q == DONE;
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        div_d   = div_q;
        presc_d = presc_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        unique case (state_q)
            IDLE: if (accept) begin
                dir_d   = bus.cmd_up;
                div_d   = bus.cmd_div;
                presc_d = bus.cmd_div;
                rem_d   = bus.cmd_len;
                q_d     = bus.cmd_clr ? '0 : q_q;
                state_d = (bus.cmd_len != '0) ? RUN : DONE;
            end
            // abort outranks both the prescaler and a pending step
            RUN: if (bus.abort) begin
                state_d = IDLE;
            end else if (presc_q != '0) begin
                presc_d = presc_q - DIV_W'(1);
            end else begin
                presc_d = div_q;
                q_d     = at_edge ? (dir_q ? '0 : QMAX) : (dir_q ? q_q + WIDTH'(1) : q_q - WIDTH'(1));
                step_d  = 1'b1;
                wrap_d  = at_edge;
                rem_d   = rem_q - WIDTH'(1);
                state_d = (rem_q == WIDTH'(1)) ? DONE : RUN;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            presc_q <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            presc_q <= presc_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed and random commands checked against a timeline model of the sequencer.
module tb_counter_sequencer;
    localparam int W = 4;
    localparam int DW = 8;
    localparam int M = 1 << W;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int failed = 0;
    int mq = 0;
    always #5 clk = ~clk;
    counter_sequencer_if #(.WIDTH(W), .DIV_W(DW)) bus ();
    counter_sequencer #(.WIDTH(W), .DIV_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    // Issue one command at a negedge and follow its expected timeline cycle by cycle.
    // abort_r / rst_r: relative cycle in which abort / rst is raised (0 = never).
    task automatic run_cmd(input bit up, input bit clr, input int len, input int div,
                           input int abort_r, input int rst_r, input bit hold);
        int q0, per, last, n, ex_q;
        bit st, wr;
        chk("ready_before_cmd", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_up    = up;
        bus.cmd_clr   = clr;
        bus.cmd_len   = W'(len);
        bus.cmd_div   = DW'(div);
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            bus.cmd_up  = ~up;
            bus.cmd_clr = 1'b1;
            bus.cmd_len = W'($urandom_range(1, M - 1));
            bus.cmd_div = DW'($urandom_range(0, 5));
        end else begin
            bus.cmd_valid = 1'b0;
        end
        q0 = clr ? 0 : mq;
        per = div + 1;
        last = len * per;
        for (int r = 1; r < 300; r++) begin
            if (rst_r != 0 && r == rst_r + 1) begin
                chk("rst_q", bus.Q, 0);
                chk("rst_busy", bus.busy, 0);
                chk("rst_done", bus.done, 0);
                chk("rst_step", bus.step, 0);
                chk("rst_wrap", bus.wrap, 0);
                chk("rst_ready_low", bus.cmd_ready, 0);
                bus.cmd_valid = 1'b0;
                rst = 1'b0;
                @(negedge clk);
                chk("rst_ready_after", bus.cmd_ready, 1);
                chk("rst_no_done", bus.done, 0);
                mq = 0;
                return;
            end
            if (abort_r != 0 && r == abort_r + 1) begin
                n = (abort_r - 1) / per;
                if (n > len) n = len;
                ex_q = up ? (q0 + n) % M : ((q0 - n) % M + M) % M;
                chk("abort_q", bus.Q, ex_q);
                chk("abort_busy", bus.busy, 0);
                chk("abort_done", bus.done, 0);
                chk("abort_step", bus.step, 0);
                chk("abort_ready", bus.cmd_ready, 1);
                bus.abort = 1'b0;
                bus.cmd_valid = 1'b0;
                mq = ex_q;
                return;
            end
            n = (r - 1) / per;
            if (n > len) n = len;
            st = (r > 1) && ((r - 1) % per == 0) && ((r - 1) / per <= len);
            ex_q = up ? (q0 + n) % M : ((q0 - n) % M + M) % M;
            wr = st && (up ? (ex_q == 0) : (ex_q == M - 1));
            chk("q", bus.Q, ex_q);
            chk("step", bus.step, st);
            chk("wrap", bus.wrap, wr);
            chk("busy", bus.busy, r <= last);
            chk("done", bus.done, r == last + 1);
            chk("ready", bus.cmd_ready, r >= last + 2);
            if (r == last + 2) begin
                bus.cmd_valid = 1'b0;
                mq = ex_q;
                return;
            end
            if (r == abort_r) bus.abort = 1'b1;
            if (r == rst_r) rst = 1'b1;
            @(negedge clk);
        end
        chk("timeout", 0, 1);
    endtask
    initial begin
        int len, div, ab, last;
        bus.cmd_valid = 1'b0;
        bus.cmd_up = 1'b0;
        bus.cmd_clr = 1'b0;
        bus.cmd_len = '0;
        bus.cmd_div = '0;
        bus.abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", bus.cmd_ready, 0);
        chk("reset_q", bus.Q, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_step", bus.step, 0);
        chk("reset_wrap", bus.wrap, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", bus.cmd_ready, 1);
        @(negedge clk);
        run_cmd(1, 0, 3, 0, 0, 0, 0);
        run_cmd(0, 1, 2, 0, 0, 0, 0);
        run_cmd(1, 0, 2, 0, 0, 0, 0);
        run_cmd(1, 0, 5, 0, 0, 0, 0);
        run_cmd(1, 0, 2, 2, 0, 0, 0);
        run_cmd(1, 1, 10, 0, 3, 0, 0);
        run_cmd(1, 0, 1, 1, 0, 0, 0);
        run_cmd(0, 0, 0, 3, 0, 0, 0);
        run_cmd(1, 1, 0, 0, 0, 0, 0);
        run_cmd(0, 0, 5, 0, 0, 0, 0);
        run_cmd(1, 0, 8, 0, 0, 4, 0);
        run_cmd(1, 0, 2, 0, 0, 3, 0);
        run_cmd(0, 0, 4, 1, 0, 0, 1);
        run_cmd(1, 0, 3, 0, 2, 0, 1);
        for (int i = 0; i < 30; i++) begin
            len = $urandom_range(0, 6);
            div = $urandom_range(0, 3);
            last = len * (div + 1);
            ab = (len > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, last) : 0;
            run_cmd(1'($urandom), 1'($urandom_range(0, 3) == 0), len, div, ab, 0, 1'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
